cpu_uart: RTL

// - CPU-bus UART peripheral at 0x5000_0000; serial link used by the boot ROM to receive the program image.
// - RX deserializer feeds an RX FIFO; CPU polls STATUS and pops DATA. Single-byte TX shifter for console output.

---
 rtl/cpu_uart_if.sv | 20 ++
 rtl/cpu_uart.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_uart_if.sv
// cpu_uart_if: CPU bus access port of the UART peripheral.
// One-cycle request strobe, registered single-cycle acknowledge.
interface cpu_uart_if;
  logic        bus_request;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_request, bus_wmask, bus_address, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_request, bus_wmask, bus_address, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/cpu_uart.sv
// cpu_uart: CPU-bus UART with RX FIFO and single-byte TX shifter.
// Define CPU_UART_FLOW_CONTROL_EN to enable RTS/CTS flow control.
module cpu_uart #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 1_000_000,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  cpu_uart_if.slave  bus,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       uart_cts,
  output logic       uart_rts
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;
  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_push, rx_ferr, rx_s;

  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_load, tx_go;

  logic [7:0]    mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, full, pop, push_ok, ovr_evt;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;

  logic          ack_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          is_wr, rd_stat, rd_data, wr_stat, wr_data;
  logic [31:0]   status;

  assign is_wr   = |bus.bus_wmask;
  assign rd_stat = bus.bus_request && !is_wr && !bus.bus_address[2];
  assign rd_data = bus.bus_request && !is_wr && bus.bus_address[2];
  assign wr_stat = bus.bus_request && bus.bus_wmask[0]
                 && !bus.bus_address[2];
  assign wr_data = bus.bus_request && bus.bus_wmask[0]
                 && bus.bus_address[2];

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign pop     = rd_data && !empty;
  assign push_ok = rx_push && (!full || pop);
  assign ovr_evt = rx_push && full && !pop;
  assign status  = {28'd0, ferr_q, ovr_q, tx_busy_q, !empty};

  assign tx_load = wr_data && !tx_busy_q;
  assign rx_s    = sync_q[1];

`ifdef CPU_UART_FLOW_CONTROL_EN
  assign tx_go    = !uart_cts;
  assign uart_rts = (cnt_q >= CNT_FULL - (AW+1)'(2));
  logic unused_ok;
  assign unused_ok = ^{bus.bus_address[31:3],
                       bus.bus_address[1:0], bus.bus_wdata[31:8]};
`else
  assign tx_go    = 1'b1;
  assign uart_rts = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{uart_cts, bus.bus_address[31:3],
                       bus.bus_address[1:0], bus.bus_wdata[31:8]};
`endif

  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;

  always_comb begin
    rdata_d = '0;
    if (rd_stat) rdata_d = status;
    else if (rd_data && !empty) rdata_d = {24'd0, mem_q[rptr_q]};
    wptr_d = wptr_q + AW'(push_ok);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q;
    if (push_ok && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - (AW+1)'(1);
    ovr_d  = (ovr_q && !(wr_stat && bus.bus_wdata[2])) || ovr_evt;
    ferr_d = (ferr_q && !(wr_stat && bus.bus_wdata[3])) || rx_ferr;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_state_d = RX_IDLE;
        rx_push    = rx_s;
        rx_ferr    = !rx_s;
      end
    endcase
  end

  // A byte may be held in IDLE while the far end deasserts CTS.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_load ? bus.bus_wdata[7:0] : tx_byte_q;
    tx_busy_d  = tx_busy_q || tx_load;
    uart_txd   = 1'b1;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if ((tx_busy_q || tx_load) && tx_go) tx_state_d = TX_START;
      end
      TX_START: begin
        uart_txd = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        uart_txd = tx_byte_q[tx_bit_q];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = TX_IDLE;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_busy_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      sync_q     <= {sync_q[0], uart_rxd};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_busy_q  <= tx_busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      ack_q      <= bus.bus_request;
      rdata_q    <= rdata_d;
    end
  end
endmodule
